// File: rtl/i2s_slave_transceiver.sv
// Philips-I2S target: recovers SCK/WS/SD with clk, deserialises a stereo rx pair and serialises a stereo tx pair.
// Latency: rx_valid rises SYNC_STAGES+2 clk after the SCK rise carrying the right LSB; sd_out moves 1 clk after the synced fall.
// Backpressure: rx pair is held until rx_ready (a newer pair is dropped with rx_overrun); one tx holding pair, tx_underrun sends zeros.
module i2s_slave_transceiver #(
    parameter int SAMPLE_BITS = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SAMPLE_BITS-1:0] tx_sample_l,
    input  logic [SAMPLE_BITS-1:0] tx_sample_r,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [SAMPLE_BITS-1:0] rx_sample_l,
    output logic [SAMPLE_BITS-1:0] rx_sample_r,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    input  logic                   i2s_sck,
    input  logic                   i2s_ws,
    input  logic                   i2s_sd_in,
    output logic                   i2s_sd_out,
    output logic                   locked,
    output logic                   frame_err,
    output logic                   tx_underrun,
    output logic                   rx_overrun
);

    localparam int KW = $clog2(SAMPLE_BITS + 2);
    localparam logic [KW-1:0] K_LAST = KW'(SAMPLE_BITS);
    localparam logic [KW-1:0] K_SAT  = KW'(SAMPLE_BITS + 1);

    logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
    logic                   sck_d;
    logic                   ws_last;
    logic [KW-1:0]          k;
    logic [SAMPLE_BITS-1:0] rx_shift, left_stage;
    logic                   have_left;
    logic                   right_done;
    logic [SAMPLE_BITS-1:0] hold_l, hold_r;
    logic [SAMPLE_BITS-1:0] frame_l, frame_r;
    logic [SAMPLE_BITS-1:0] tx_shift;

    logic                   sck_s, ws_s, sd_s;
    logic                   rise, fall, ws_chg, left_start;
    logic [KW-1:0]          k_nxt;
    logic [SAMPLE_BITS-1:0] shift_in;
    logic [SAMPLE_BITS-1:0] frame_l_nxt, frame_r_nxt;

    always_comb begin
        sck_s      = sck_sync[SYNC_STAGES-1];
        ws_s       = ws_sync[SYNC_STAGES-1];
        sd_s       = sd_sync[SYNC_STAGES-1];
        rise       = sck_s & ~sck_d;
        fall       = ~sck_s & sck_d;
        ws_chg     = ws_s != ws_last;
        left_start = rise & ws_last & ~ws_s;
        k_nxt      = ws_chg ? '0 : ((k == K_SAT) ? K_SAT : k + KW'(1));
        shift_in   = {rx_shift[SAMPLE_BITS-2:0], sd_s};
        // Left start moves the holding pair (or zeros on underrun) into the frame registers.
        frame_l_nxt = frame_l;
        frame_r_nxt = frame_r;
        if (left_start) begin
            frame_l_nxt = tx_ready ? '0 : hold_l;
            frame_r_nxt = tx_ready ? '0 : hold_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync    <= '0;
            ws_sync     <= '0;
            sd_sync     <= '0;
            sck_d       <= 1'b0;
            ws_last     <= 1'b0;
            k           <= '0;
            locked      <= 1'b0;
            rx_shift    <= '0;
            left_stage  <= '0;
            have_left   <= 1'b0;
            right_done  <= 1'b0;
            rx_sample_l <= '0;
            rx_sample_r <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            tx_ready    <= 1'b1;
            frame_l     <= '0;
            frame_r     <= '0;
            tx_shift    <= '0;
            i2s_sd_out  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], i2s_sck};
            ws_sync     <= {ws_sync[SYNC_STAGES-2:0], i2s_ws};
            sd_sync     <= {sd_sync[SYNC_STAGES-2:0], i2s_sd_in};
            sck_d       <= sck_s;
            frame_err   <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            right_done  <= 1'b0;

            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (right_done) begin
                if (!rx_valid) begin
                    rx_sample_l <= left_stage;
                    rx_sample_r <= rx_shift;
                    rx_valid    <= 1'b1;
                end else begin
                    rx_overrun  <= 1'b1;
                end
            end

            if (rise) begin
                k       <= k_nxt;
                ws_last <= ws_s;
                if (left_start) begin
                    locked    <= 1'b1;
                    have_left <= 1'b0;
                end
                // WS moved before the word finished: discard this frame's pairing.
                if (ws_chg && locked && k < K_LAST) begin
                    frame_err <= 1'b1;
                    have_left <= 1'b0;
                end
                if (k_nxt != '0 && k_nxt <= K_LAST)
                    rx_shift <= shift_in;
                if (k_nxt == K_LAST && locked) begin
                    if (!ws_s) begin
                        left_stage <= shift_in;
                        have_left  <= 1'b1;
                    end else if (have_left) begin
                        right_done <= 1'b1;
                        have_left  <= 1'b0;
                    end
                end
                if (k_nxt == '0)
                    tx_shift <= ws_s ? frame_r_nxt : frame_l_nxt;
            end

            if (fall) begin
                if (locked && k < K_LAST) begin
                    i2s_sd_out <= tx_shift[SAMPLE_BITS-1];
                    tx_shift   <= tx_shift << 1;
                end else begin
                    i2s_sd_out <= 1'b0;
                end
            end

            if (left_start) begin
                frame_l <= frame_l_nxt;
                frame_r <= frame_r_nxt;
                if (tx_ready)
                    tx_underrun <= 1'b1;
                else
                    tx_ready    <= 1'b1;
            end
            // An accept coinciding with left start lands in holding for the following frame.
            if (tx_valid && tx_ready) begin
                hold_l   <= tx_sample_l;
                hold_r   <= tx_sample_r;
                tx_ready <= 1'b0;
            end
        end
    end

endmodule
